regfile_wb_sequencer: RTL and testbench
=======================================

# regfile_wb_sequencer

Write-back sequencer for the 32x32 register block. Two producers, the ALU and the load/store unit, share the register block's single write port. The block arbitrates between them round-robin and drives the port's regWrite/byteOperations/write_reg/write_data from one registered stage. It also keeps a busy scoreboard of destination registers that have been issued but not yet written, and flags read-after-write hazards for the decode stage.

## Interface
Parameters:
- DATA_W, 32, register data width.
- REG_AW, 5, register address width; the scoreboard has 2**REG_AW entries.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- issue_valid  in  1  decode requests to reserve a destination register.
- issue_rd  in  REG_AW  destination register to reserve.
- issue_busy  out  1  combinational; busy[issue_rd] && issue_rd!=0; the issue is accepted only when this is low.
- read_reg1, read_reg2  in  REG_AW  source registers of the instruction in decode.
- hazard  out  1  combinational; a source register is busy (register 0 is never busy).
- alu_valid, alu_ready  in/out  1  ALU write-back handshake.
- alu_reg  in  REG_AW; alu_data  in  DATA_W; alu_byte  in  1  (alu_byte=1 selects a byte write).
- mem_valid, mem_ready  in/out  1  load-unit write-back handshake.
- mem_reg  in  REG_AW; mem_data  in  DATA_W; mem_byte  in  1.
- rf_regWrite  out  1  write strobe to the register block, asserted for one cycle per write.
- rf_byteOperations  out  1  byte-write mode to the register block.
- rf_write_reg  out  REG_AW; rf_write_data  out  DATA_W  write address and data.
- fwd1_hit, fwd2_hit  out  1; fwd_data  out  DATA_W  present only with WB_BYPASS_EN.

## Operation
- Arbitration: a requester is granted when its valid is high and it is selected by the rule below.
  - If only one requester is valid, it is granted.
  - If both are valid, the one not granted last time (last_grant flop) is granted.
  - ready is combinational and equals the grant. The losing requester holds valid, reg, data and byte stable until it is granted.
- The write port never back-pressures, so at most one write is accepted per cycle.
- Output stage: on accept, rf_write_reg, rf_byteOperations and rf_write_data are registered.
  - If the accepted byte flag is 1, the registered data is {zeros, data[7:0]}.
  - rf_regWrite=1 for the following cycle; otherwise rf_regWrite=0.
- Register 0: a write to register 0 is accepted (the ready handshake completes) but rf_regWrite stays 0. The scoreboard never sets busy[0].
- Scoreboard:
  - An accepted issue (issue_valid && !issue_busy) sets busy[issue_rd] at the edge.
  - busy[rf_write_reg] clears at the edge that ends the cycle in which rf_regWrite=1.
  - If a set and a clear of the same register land on the same edge, the set wins.
- A write-back to a register that is not busy is still performed and leaves busy unchanged.
- Reset values: rf_regWrite=0, rf_byteOperations=0, rf_write_reg=0, rf_write_data=0, all busy bits 0, last_grant=MEM (the ALU wins the first tie), fwd*_hit=0.
- Reset asserted mid-operation: an in-flight rf write is dropped and all reservations are lost.

## Timing
- Accept-to-strobe latency is 1 cycle. If a handshake completes at edge N, rf_regWrite is high from edge N to edge N+1.
- Throughput is one write per cycle. Alternating or back-to-back grants produce a continuous rf_regWrite.
- The busy bit clears at edge N+1. Without bypass, hazard stays asserted through cycle N+1 and drops in cycle N+2.
- issue_busy and hazard depend only on the busy flops and the current inputs, not on this cycle's write-back handshake.

## Configuration
- WB_BYPASS_EN undefined:
  - no fwd ports;
  - hazard reflects the busy bits only.
- WB_BYPASS_EN defined:
  - While rf_regWrite=1, a source equal to rf_write_reg (non-zero) is excluded from hazard.
  - fwd1_hit/fwd2_hit flag a match on read_reg1/read_reg2, and fwd_data=rf_write_data.
  - This removes one stall cycle per dependent read.

## Test plan
- Reset then idle: all rf_* outputs 0, hazard=0 for any read_reg, and issue_busy=0 while issue_valid is held.
- Issue rd=5, then ALU writes reg 5 data 0x12345678 one cycle later:
  - alu_ready=1 in that cycle;
  - rf_regWrite=1 with reg 5 / 0x12345678 in the next cycle;
  - hazard for read_reg1=5 is high from the issue until 2 cycles after accept (1 cycle with WB_BYPASS_EN, fwd1_hit=1, fwd_data=0x12345678).
- alu_valid and mem_valid held high for 4 cycles (regs 1/2) after reset: grants go ALU, MEM, ALU, MEM, and rf_regWrite is high for 4 consecutive cycles.
- Load-unit byte write mem_byte=1, data 0xAABBCCDD, reg 7: rf_write_data=0x000000DD and rf_byteOperations=1.
- ALU write to reg 0 with data 0xFFFFFFFF: alu_ready=1, rf_regWrite stays 0, and issue_rd=0 gives issue_busy=0.
- Issue rd=9 and ALU write of reg 9 completing on the same edge as the busy-clear of an earlier reg-9 write: busy[9] remains set.
- Assert reset while rf_regWrite=1 for reg 9: rf_regWrite drops to 0 immediately and hazard for reg 9 reads 0.

Source files
------------

// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer
// Write-back sequencer for the 32x32 register block. Two write-back
// producers (ALU and load/store unit) share the register block's single
// write port. A round-robin arbiter picks one producer per cycle and the
// winner's write is registered into the rf_* outputs. A busy scoreboard
// tracks destination registers that decode has reserved but that have not
// been written yet, and raises a read-after-write hazard for decode.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, a source register that is being written this cycle
//   (rf_regWrite=1, same non-zero register) is not reported as a hazard.
//   The value is offered on fwd_data, and fwd1_hit/fwd2_hit say which
//   source matched.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   issue_valid/issue_rd  decode reserves a destination register
//   issue_busy            destination already reserved (issue must wait)
//   read_reg1/read_reg2   source registers of the instruction in decode
//   hazard                a source register is still pending a write
//   alu_*                 ALU write-back request (valid/ready handshake)
//   mem_*                 load-unit write-back request (valid/ready)
//   rf_*                  registered write port to the register block
//   fwd1_hit/fwd2_hit/fwd_data   bypass outputs (WB_BYPASS_EN only)

module regfile_wb_sequencer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    output logic              issue_busy,
    input  logic [REG_AW-1:0] read_reg1,
    input  logic [REG_AW-1:0] read_reg2,
    output logic              hazard,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              alu_byte,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [REG_AW-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_byte,
    output logic              rf_regWrite,
    output logic              rf_byteOperations,
    output logic [REG_AW-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data
`ifdef WB_BYPASS_EN
    ,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int NUM_REGS = 2 ** REG_AW;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t              last_grant;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    logic                alu_grant;
    logic                mem_grant;
    logic                wb_accept;
    logic [REG_AW-1:0]   sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_byte;
    logic                issue_accept;
    logic                src1_busy;
    logic                src2_busy;

    // Round-robin arbiter: on a tie, the producer that did not win last
    // time gets the port. The write port never stalls, so ready is just
    // the grant and at most one write is taken per cycle.
    always_comb begin
        alu_grant = alu_valid && (!mem_valid || (last_grant == GRANT_MEM));
        mem_grant = mem_valid && !alu_grant;
        wb_accept = alu_grant || mem_grant;
    end

    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;

    // Winner's write-back fields. Byte writes keep only the low byte so the
    // register block sees a zero-extended value.
    always_comb begin
        sel_reg  = alu_reg;
        sel_data = alu_data;
        sel_byte = alu_byte;
        if (mem_grant) begin
            sel_reg  = mem_reg;
            sel_data = mem_data;
            sel_byte = mem_byte;
        end
        if (sel_byte) begin
            sel_data = {{(DATA_W-8){1'b0}}, sel_data[7:0]};
        end
    end

    // Remember who won last so ties alternate. Reset to MEM so the ALU
    // wins the very first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_MEM;
        end else if (alu_grant) begin
            last_grant <= GRANT_ALU;
        end else if (mem_grant) begin
            last_grant <= GRANT_MEM;
        end
    end

    // Registered write port. A write to register 0 still completes the
    // handshake but never raises the strobe, since register 0 is constant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_regWrite       <= 1'b0;
            rf_byteOperations <= 1'b0;
            rf_write_reg      <= '0;
            rf_write_data     <= '0;
        end else if (wb_accept) begin
            rf_regWrite       <= (sel_reg != '0);
            rf_byteOperations <= sel_byte;
            rf_write_reg      <= sel_reg;
            rf_write_data     <= sel_data;
        end else begin
            rf_regWrite       <= 1'b0;
        end
    end

    // A register is reserved by an accepted issue and released when its
    // write strobe has been on the port for a cycle. The set is applied
    // after the clear so a new reservation survives a release of the same
    // register on the same edge. Register 0 is never reserved.
    assign issue_busy   = busy[issue_rd] && (issue_rd != '0);
    assign issue_accept = issue_valid && !issue_busy;

    always_comb begin
        busy_next = busy;
        if (rf_regWrite) begin
            busy_next[rf_write_reg] = 1'b0;
        end
        if (issue_accept) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Hazard looks only at the reservation flops and decode's sources, so
    // this cycle's write-back handshake cannot feed back into decode.
    assign src1_busy = busy[read_reg1] && (read_reg1 != '0);
    assign src2_busy = busy[read_reg2] && (read_reg2 != '0);

`ifdef WB_BYPASS_EN
    // A source being written this cycle can take its value from the write
    // port instead of waiting a further cycle for the register block.
    // rf_regWrite is never high for register 0, so no extra zero check.
    assign fwd1_hit = rf_regWrite && (read_reg1 == rf_write_reg);
    assign fwd2_hit = rf_regWrite && (read_reg2 == rf_write_reg);
    assign fwd_data = rf_write_data;
    assign hazard   = (src1_busy && !fwd1_hit) || (src2_busy && !fwd2_hit);
`else
    assign hazard   = src1_busy || src2_busy;
`endif

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// tb_regfile_wb_sequencer
// Self-checking bench for regfile_wb_sequencer. Each scenario drives its
// stimulus and pushes the write the register block should see onto a
// queue; a monitor pops and compares whenever rf_regWrite is high.
// Handles both the default build and the WB_BYPASS_EN build.

module tb_regfile_wb_sequencer;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
        logic        b;
    } wb_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rd;
    logic              issue_busy;
    logic [REG_AW-1:0] read_reg1;
    logic [REG_AW-1:0] read_reg2;
    logic              hazard;
    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_byte;
    logic              mem_valid;
    logic              mem_ready;
    logic [REG_AW-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              mem_byte;
    logic              rf_regWrite;
    logic              rf_byteOperations;
    logic [REG_AW-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
`ifdef WB_BYPASS_EN
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    wb_t exp_q[$];
    wb_t exp_e;
    int  checks = 0;
    int  errors = 0;

    regfile_wb_sequencer #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .issue_valid       (issue_valid),
        .issue_rd          (issue_rd),
        .issue_busy        (issue_busy),
        .read_reg1         (read_reg1),
        .read_reg2         (read_reg2),
        .hazard            (hazard),
        .alu_valid         (alu_valid),
        .alu_ready         (alu_ready),
        .alu_reg           (alu_reg),
        .alu_data          (alu_data),
        .alu_byte          (alu_byte),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .mem_reg           (mem_reg),
        .mem_data          (mem_data),
        .mem_byte          (mem_byte),
        .rf_regWrite       (rf_regWrite),
        .rf_byteOperations (rf_byteOperations),
        .rf_write_reg      (rf_write_reg),
        .rf_write_data     (rf_write_data)
`ifdef WB_BYPASS_EN
        ,
        .fwd1_hit          (fwd1_hit),
        .fwd2_hit          (fwd2_hit),
        .fwd_data          (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge so new inputs are stable
    // well before the following edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus_idle();
        issue_valid = 1'b0;
        issue_rd    = '0;
        read_reg1   = '0;
        read_reg2   = '0;
        alu_valid   = 1'b0;
        alu_reg     = '0;
        alu_data    = '0;
        alu_byte    = 1'b0;
        mem_valid   = 1'b0;
        mem_reg     = '0;
        mem_data    = '0;
        mem_byte    = 1'b0;
    endtask

    task automatic do_reset();
        applyStimulus_idle();
        reset = 1'b1;
        exp_q.delete();
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every strobe on the write port must match the
    // oldest outstanding expected write.
    task automatic scoreboard_monitor();
        forever begin
            @(negedge clk);
            if (rf_regWrite === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL wb_unexpected: got reg %0d data %h byte %b, expected no write",
                             rf_write_reg, rf_write_data, rf_byteOperations);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (rf_write_reg !== exp_e.r || rf_write_data !== exp_e.d ||
                        rf_byteOperations !== exp_e.b) begin
                        errors++;
                        $display("[TB] FAIL wb_data: got reg %0d data %h byte %b, expected reg %0d data %h byte %b",
                                 rf_write_reg, rf_write_data, rf_byteOperations,
                                 exp_e.r, exp_e.d, exp_e.b);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        applyStimulus_idle();
        reset = 1'b1;
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue_rd  = REG_AW'(i * 9 + 1);
            read_reg1 = REG_AW'(i * 7 + 3);
            read_reg2 = REG_AW'(31 - i);
            @(negedge clk);
            checks++;
            if (rf_regWrite !== 1'b0 || rf_byteOperations !== 1'b0 ||
                rf_write_reg !== '0 || rf_write_data !== '0) begin
                errors++;
                $display("[TB] FAIL reset_rf: got we %b byte %b reg %0d data %h, expected all 0",
                         rf_regWrite, rf_byteOperations, rf_write_reg, rf_write_data);
            end
            checks++;
            if (hazard !== 1'b0 || issue_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_busy: got hazard %b issue_busy %b, expected 0 0",
                         hazard, issue_busy);
            end
        end
        applyStimulus_idle();
        next_cycle();
        reset = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (rf_regWrite !== 1'b0 || hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got we %b hazard %b, expected 0 0",
                     rf_regWrite, hazard);
        end
    endtask

    task automatic test_raw_hazard();
        $display("[TB] test_raw_hazard");
        next_cycle();
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        read_reg1   = 5'd5;
        @(negedge clk);
        checks++;
        if (issue_busy !== 1'b0 || hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL raw_issue: got issue_busy %b hazard %b, expected 0 0", issue_busy, hazard);
        end
        next_cycle();
        issue_valid = 1'b0;
        alu_valid   = 1'b1;
        alu_reg     = 5'd5;
        alu_data    = 32'h12345678;
        alu_byte    = 1'b0;
        exp_q.push_back('{r: 5'd5, d: 32'h12345678, b: 1'b0});
        @(negedge clk);
        checks++;
        if (alu_ready !== 1'b1 || hazard !== 1'b1 || issue_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL raw_accept: got alu_ready %b hazard %b issue_busy %b, expected 1 1 1",
                     alu_ready, hazard, issue_busy);
        end
        next_cycle();
        alu_valid = 1'b0;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        checks++;
        if (hazard !== 1'b0 || fwd1_hit !== 1'b1 || fwd_data !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL raw_bypass: got hazard %b fwd1_hit %b fwd_data %h, expected 0 1 12345678",
                     hazard, fwd1_hit, fwd_data);
        end
`else
        checks++;
        if (hazard !== 1'b1 || rf_regWrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL raw_strobe_cycle: got hazard %b we %b, expected 1 1", hazard, rf_regWrite);
        end
`endif
        next_cycle();
        @(negedge clk);
        checks++;
        if (hazard !== 1'b0 || rf_regWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL raw_release: got hazard %b we %b, expected 0 0", hazard, rf_regWrite);
        end
        read_reg1 = '0;
    endtask

    task automatic test_back_to_back();
        logic model_last_alu;
        logic exp_alu;
        $display("[TB] test_back_to_back");
        do_reset();
        model_last_alu = 1'b0;
        alu_valid = 1'b1;
        alu_reg   = 5'd1;
        alu_data  = 32'hA000_0000;
        mem_valid = 1'b1;
        mem_reg   = 5'd2;
        mem_data  = 32'hB000_0000;
        for (int i = 0; i < 4; i++) begin
            exp_alu = !model_last_alu;
            if (exp_alu) exp_q.push_back('{r: 5'd1, d: alu_data, b: 1'b0});
            else         exp_q.push_back('{r: 5'd2, d: mem_data, b: 1'b0});
            @(negedge clk);
            checks++;
            if (alu_ready !== exp_alu || mem_ready !== !exp_alu) begin
                errors++;
                $display("[TB] FAIL b2b_grant%0d: got alu_ready %b mem_ready %b, expected %b %b",
                         i, alu_ready, mem_ready, exp_alu, !exp_alu);
            end
            checks++;
            if (rf_regWrite !== (i > 0)) begin
                errors++;
                $display("[TB] FAIL b2b_strobe%0d: got we %b, expected %b", i, rf_regWrite, (i > 0));
            end
            next_cycle();
            model_last_alu = exp_alu;
            if (exp_alu) alu_data = alu_data + 32'd1;
            else         mem_data = mem_data + 32'd1;
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rf_regWrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_last_strobe: got we %b, expected 1", rf_regWrite);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rf_regWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end: got we %b, expected 0", rf_regWrite);
        end
    endtask

    task automatic test_byte_write();
        $display("[TB] test_byte_write");
        next_cycle();
        mem_valid = 1'b1;
        mem_reg   = 5'd7;
        mem_data  = 32'hAABBCCDD;
        mem_byte  = 1'b1;
        exp_q.push_back('{r: 5'd7, d: 32'h000000DD, b: 1'b1});
        @(negedge clk);
        checks++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL byte_grant: got mem_ready %b alu_ready %b, expected 1 0", mem_ready, alu_ready);
        end
        next_cycle();
        mem_valid = 1'b0;
        mem_byte  = 1'b0;
        @(negedge clk);
        checks++;
        if (rf_byteOperations !== 1'b1 || rf_write_data !== 32'h000000DD) begin
            errors++;
            $display("[TB] FAIL byte_data: got byte %b data %h, expected 1 000000dd",
                     rf_byteOperations, rf_write_data);
        end
    endtask

    task automatic test_reg0();
        $display("[TB] test_reg0");
        next_cycle();
        alu_valid   = 1'b1;
        alu_reg     = 5'd0;
        alu_data    = 32'hFFFFFFFF;
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        @(negedge clk);
        checks++;
        if (alu_ready !== 1'b1 || issue_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reg0_accept: got alu_ready %b issue_busy %b, expected 1 0", alu_ready, issue_busy);
        end
        next_cycle();
        alu_valid   = 1'b0;
        issue_valid = 1'b0;
        read_reg1   = 5'd0;
        @(negedge clk);
        checks++;
        if (rf_regWrite !== 1'b0 || hazard !== 1'b0 || issue_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reg0_no_write: got we %b hazard %b issue_busy %b, expected 0 0 0",
                     rf_regWrite, hazard, issue_busy);
        end
    endtask

    task automatic test_set_clear_collision();
        $display("[TB] test_set_clear_collision");
        next_cycle();
        // First write to reg 9 while it is not reserved.
        alu_valid = 1'b1;
        alu_reg   = 5'd9;
        alu_data  = 32'h0000_0901;
        exp_q.push_back('{r: 5'd9, d: 32'h0000_0901, b: 1'b0});
        next_cycle();
        // Strobe for reg 9 is on the port; reserve reg 9 and send a second write.
        alu_data    = 32'h0000_0902;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        exp_q.push_back('{r: 5'd9, d: 32'h0000_0902, b: 1'b0});
        @(negedge clk);
        checks++;
        if (issue_busy !== 1'b0 || alu_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collide_issue: got issue_busy %b alu_ready %b, expected 0 1", issue_busy, alu_ready);
        end
        next_cycle();
        alu_valid   = 1'b0;
        issue_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (issue_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collide_set_wins: got busy9 %b, expected 1", issue_busy);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (issue_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL collide_release: got busy9 %b, expected 0", issue_busy);
        end
        issue_rd = '0;
    endtask

    task automatic test_reset_midop();
        $display("[TB] test_reset_midop");
        next_cycle();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        next_cycle();
        issue_valid = 1'b0;
        alu_valid   = 1'b1;
        alu_reg     = 5'd9;
        alu_data    = 32'hDEAD_0009;
        exp_q.push_back('{r: 5'd9, d: 32'hDEAD_0009, b: 1'b0});
        next_cycle();
        alu_valid = 1'b0;
        read_reg1 = 5'd9;
        checks++;
        if (rf_regWrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midop_pre: got we %b, expected 1", rf_regWrite);
        end
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (rf_regWrite !== 1'b0 || hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midop_reset: got we %b hazard %b, expected 0 0", rf_regWrite, hazard);
        end
        next_cycle();
        reset = 1'b0;
        applyStimulus_idle();
        next_cycle();
    endtask

    initial begin
        fork
            scoreboard_monitor();
        join_none
        applyStimulus_idle();
        reset = 1'b1;
        test_reset();
        test_raw_hazard();
        test_back_to_back();
        test_byte_write();
        test_reg0();
        test_set_clear_collision();
        test_reset_midop();
        next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL wb_missing: got %0d writes still outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
